// File: rtl/vote_tally_n_if.sv
// Ballot/result bundle between the ballot front-end (master) and the vote tally block (slave).
interface vote_tally_n_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = $clog2(N + 1)
);
  logic             start;
  logic             close;
  logic             ballot_valid;
  logic [N-1:0]     ballot;
  logic [N-1:0]     present;
  logic             busy;
  logic [N-1:0]     voted;
  logic [CNT_W-1:0] yes_cnt;
  logic [CNT_W-1:0] no_cnt;
  logic             result_valid;
  logic             maj;
  logic             uni;
  logic             tie;
  logic             none;
  logic             dup_err;

  modport master (
    output start, close, ballot_valid, ballot, present,
    input  busy, voted, yes_cnt, no_cnt, result_valid, maj, uni, tie, none, dup_err
  );

  modport slave (
    input  start, close, ballot_valid, ballot, present,
    output busy, voted, yes_cnt, no_cnt, result_valid, maj, uni, tie, none, dup_err
  );
endinterface

// File: rtl/vote_tally_n.sv
// N-voter session tally: accumulates one ballot per voter per session and
// registers majority / unanimous / tie / no-quorum flags when the session ends.
module vote_tally_n #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = $clog2(N + 1)
) (
  input logic          clk,
  input logic          rst_n,
  vote_tally_n_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OPEN, RESULT} state_t;

  state_t state;

  logic [N-1:0]     fresh;
  logic [N-1:0]     dup;
  logic [N-1:0]     voted_nxt;
  logic [CNT_W-1:0] yes_nxt;
  logic [CNT_W-1:0] no_nxt;
  logic [CNT_W-1:0] fin_yes;
  logic [CNT_W-1:0] fin_no;
  logic [CNT_W:0]   fin_cast;
  logic             fin_none;
  logic             auto_close;

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < N; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Ballot accounting for this cycle; final counts include a ballot arriving with close.
  always_comb begin
    fresh      = bus.present & ~bus.voted;
    dup        = bus.present & bus.voted;
    voted_nxt  = bus.voted | fresh;
    yes_nxt    = bus.yes_cnt + popcount(fresh & bus.ballot);
    no_nxt     = bus.no_cnt + popcount(fresh & ~bus.ballot);
    fin_yes    = bus.ballot_valid ? yes_nxt : bus.yes_cnt;
    fin_no     = bus.ballot_valid ? no_nxt : bus.no_cnt;
    fin_cast   = {1'b0, fin_yes} + {1'b0, fin_no};
    fin_none   = (fin_cast == '0);
    auto_close = bus.ballot_valid && (&voted_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      bus.busy         <= 1'b0;
      bus.voted        <= '0;
      bus.yes_cnt      <= '0;
      bus.no_cnt       <= '0;
      bus.result_valid <= 1'b0;
      bus.maj          <= 1'b0;
      bus.uni          <= 1'b0;
      bus.tie          <= 1'b0;
      bus.none         <= 1'b0;
      bus.dup_err      <= 1'b0;
    end else begin
      bus.result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= OPEN;
            bus.busy    <= 1'b1;
            bus.voted   <= '0;
            bus.yes_cnt <= '0;
            bus.no_cnt  <= '0;
            bus.dup_err <= 1'b0;
            bus.maj     <= 1'b0;
            bus.uni     <= 1'b0;
            bus.tie     <= 1'b0;
            bus.none    <= 1'b0;
          end
        end
        OPEN: begin
          if (bus.start) begin
            // Restart wins over close and any ballot in the same cycle.
            bus.voted   <= '0;
            bus.yes_cnt <= '0;
            bus.no_cnt  <= '0;
            bus.dup_err <= 1'b0;
          end else begin
            if (bus.ballot_valid) begin
              bus.voted   <= voted_nxt;
              bus.yes_cnt <= yes_nxt;
              bus.no_cnt  <= no_nxt;
              if (|dup) bus.dup_err <= 1'b1;
            end
            if (bus.close || auto_close) begin
              state            <= RESULT;
              bus.busy         <= 1'b0;
              bus.result_valid <= 1'b1;
              bus.none         <= fin_none;
              bus.maj          <= !fin_none && (fin_yes > fin_no);
              bus.tie          <= !fin_none && (fin_yes == fin_no);
              bus.uni          <= !fin_none && ((fin_yes == '0) || (fin_no == '0));
            end
          end
        end
        RESULT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_tally_n.sv
// Bench for vote_tally_n: directed plan plus random sessions on N=4 against a
// voter-level reference model, and a directed N=7 session.
module tb_vote_tally_n;

  logic clk;
  logic rst_n;

  vote_tally_n_if #(.N(4)) a_if ();
  vote_tally_n_if #(.N(7)) b_if ();

  vote_tally_n #(.N(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  vote_tally_n #(.N(7)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state for the N=4 instance.
  int       m_phase;  // 0 idle, 1 session open, 2 result cycle
  bit       m_has_cast [4];
  int       m_yes, m_no;
  bit       m_dup, m_busy, m_rv, m_maj, m_uni, m_tie, m_none;

  task automatic model_reset();
    m_phase = 0;
    for (int i = 0; i < 4; i++) m_has_cast[i] = 1'b0;
    m_yes = 0; m_no = 0;
    m_dup = 0; m_busy = 0; m_rv = 0;
    m_maj = 0; m_uni = 0; m_tie = 0; m_none = 0;
  endtask

  function automatic logic [3:0] model_voted();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_has_cast[i];
    return v;
  endfunction

  task automatic model_clear_session();
    for (int i = 0; i < 4; i++) m_has_cast[i] = 1'b0;
    m_yes = 0; m_no = 0; m_dup = 0;
  endtask

  task automatic model_step(input bit s, input bit c, input bit bv,
                            input logic [3:0] b, input logic [3:0] p);
    int cast;
    int n_cast;
    m_rv = 0;
    if (m_phase == 0) begin
      if (s) begin
        model_clear_session();
        m_maj = 0; m_uni = 0; m_tie = 0; m_none = 0;
        m_phase = 1; m_busy = 1;
      end
    end else if (m_phase == 1) begin
      if (s) begin
        model_clear_session();
      end else begin
        if (bv) begin
          for (int i = 0; i < 4; i++) begin
            if (p[i]) begin
              if (m_has_cast[i]) m_dup = 1;
              else begin
                m_has_cast[i] = 1;
                if (b[i]) m_yes++; else m_no++;
              end
            end
          end
        end
        n_cast = 0;
        for (int i = 0; i < 4; i++) n_cast += int'(m_has_cast[i]);
        if (c || n_cast == 4) begin
          cast   = m_yes + m_no;
          m_none = (cast == 0);
          m_maj  = (m_yes > m_no);
          m_tie  = (cast > 0) && (m_yes == m_no);
          m_uni  = (cast > 0) && (m_yes == cast || m_no == cast);
          m_rv   = 1; m_busy = 0; m_phase = 2;
        end
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".busy"},   32'(a_if.busy),         32'(m_busy));
    chk({tag, ".voted"},  32'(a_if.voted),        32'(model_voted()));
    chk({tag, ".yes"},    32'(a_if.yes_cnt),      32'(m_yes));
    chk({tag, ".no"},     32'(a_if.no_cnt),       32'(m_no));
    chk({tag, ".rv"},     32'(a_if.result_valid), 32'(m_rv));
    chk({tag, ".maj"},    32'(a_if.maj),          32'(m_maj));
    chk({tag, ".uni"},    32'(a_if.uni),          32'(m_uni));
    chk({tag, ".tie"},    32'(a_if.tie),          32'(m_tie));
    chk({tag, ".none"},   32'(a_if.none),         32'(m_none));
    chk({tag, ".dup"},    32'(a_if.dup_err),      32'(m_dup));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input bit c, input bit bv,
                       input logic [3:0] b, input logic [3:0] p, input string tag);
    a_if.start = s; a_if.close = c; a_if.ballot_valid = bv;
    a_if.ballot = b; a_if.present = p;
    model_step(s, c, bv, b, p);
    tick();
    a_if.start = 0; a_if.close = 0; a_if.ballot_valid = 0;
    a_if.ballot = '0; a_if.present = '0;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] pat;
    rst_n = 1'b0;
    a_if.start = 0; a_if.close = 0; a_if.ballot_valid = 0; a_if.ballot = '0; a_if.present = '0;
    b_if.start = 0; b_if.close = 0; b_if.ballot_valid = 0; b_if.ballot = '0; b_if.present = '0;
    model_reset();
    #1;
    check_all("reset");
    chk("reset_b.busy", 32'(b_if.busy), 32'd0);
    chk("reset_b.yes",  32'(b_if.yes_cnt), 32'd0);
    #11 rst_n = 1'b1;
    tick();
    check_all("post_reset");

    // Exhaustive single-ballot sessions with auto-close.
    for (int k = 0; k < 16; k++) begin
      pat = 4'(k);
      drive(1, 0, 0, 4'h0, 4'h0, "ex.start");
      drive(0, 0, 1, pat, 4'hF, "ex.ballot");
      if (k == 3)  begin chk("ex0011.tie", 32'(a_if.tie), 32'd1); chk("ex0011.maj", 32'(a_if.maj), 32'd0); end
      if (k == 15) begin chk("ex1111.maj", 32'(a_if.maj), 32'd1); chk("ex1111.uni", 32'(a_if.uni), 32'd1); end
      if (k == 0)  begin chk("ex0000.uni", 32'(a_if.uni), 32'd1); chk("ex0000.maj", 32'(a_if.maj), 32'd0); end
      if (k == 7)  begin
        chk("ex0111.maj", 32'(a_if.maj), 32'd1);
        chk("ex0111.yes", 32'(a_if.yes_cnt), 32'd3);
        chk("ex0111.no",  32'(a_if.no_cnt), 32'd1);
      end
      chk("ex.rv", 32'(a_if.result_valid), 32'd1);
      drive(0, 0, 0, 4'h0, 4'h0, "ex.idle");
    end

    // Multi-cycle session closed explicitly.
    drive(1, 0, 0, 4'h0, 4'h0, "mc.start");
    drive(0, 0, 1, 4'b1000, 4'b1000, "mc.b1");
    drive(0, 0, 1, 4'b0000, 4'b0100, "mc.b2");
    drive(0, 1, 0, 4'h0, 4'h0, "mc.close");
    chk("mc.yes", 32'(a_if.yes_cnt), 32'd1);
    chk("mc.no",  32'(a_if.no_cnt), 32'd1);
    chk("mc.tie", 32'(a_if.tie), 32'd1);
    chk("mc.uni", 32'(a_if.uni), 32'd0);
    chk("mc.voted", 32'(a_if.voted), 32'hC);
    drive(0, 0, 1, 4'hF, 4'hF, "mc.idle_ballot");

    // Duplicate vote.
    drive(1, 0, 0, 4'h0, 4'h0, "dup.start");
    drive(0, 0, 1, 4'b0001, 4'b0001, "dup.b1");
    drive(0, 0, 1, 4'b0000, 4'b0011, "dup.b2");
    drive(0, 1, 0, 4'h0, 4'h0, "dup.close");
    chk("dup.err", 32'(a_if.dup_err), 32'd1);
    chk("dup.voted", 32'(a_if.voted), 32'h3);
    drive(0, 0, 0, 4'h0, 4'h0, "dup.idle");

    // Empty session.
    drive(1, 0, 0, 4'h0, 4'h0, "empty.start");
    drive(0, 1, 0, 4'h0, 4'h0, "empty.close");
    chk("empty.none", 32'(a_if.none), 32'd1);
    chk("empty.rv",   32'(a_if.result_valid), 32'd1);
    drive(1, 0, 0, 4'h0, 4'h0, "empty.start_in_result");
    drive(0, 0, 0, 4'h0, 4'h0, "empty.idle");

    // Final ballot together with close.
    drive(1, 0, 0, 4'h0, 4'h0, "bc.start");
    drive(0, 1, 1, 4'b0001, 4'b0011, "bc.ballot_close");
    chk("bc.yes", 32'(a_if.yes_cnt), 32'd1);
    chk("bc.no",  32'(a_if.no_cnt), 32'd1);
    drive(0, 0, 0, 4'h0, 4'h0, "bc.idle");

    // Restart in an open session.
    drive(1, 0, 0, 4'h0, 4'h0, "rs.start");
    drive(0, 0, 1, 4'b0011, 4'b0011, "rs.b1");
    drive(1, 1, 0, 4'h0, 4'h0, "rs.restart");
    chk("rs.yes",  32'(a_if.yes_cnt), 32'd0);
    chk("rs.busy", 32'(a_if.busy), 32'd1);
    chk("rs.rv",   32'(a_if.result_valid), 32'd0);
    drive(0, 1, 0, 4'h0, 4'h0, "rs.close");
    drive(0, 0, 0, 4'h0, 4'h0, "rs.idle");

    // Asynchronous reset in the middle of an open session.
    drive(1, 0, 0, 4'h0, 4'h0, "ar.start");
    drive(0, 0, 1, 4'b0101, 4'b0111, "ar.b1");
    #2 rst_n = 1'b0;
    #1;
    chk("ar.busy",  32'(a_if.busy), 32'd0);
    chk("ar.voted", 32'(a_if.voted), 32'd0);
    chk("ar.yes",   32'(a_if.yes_cnt), 32'd0);
    chk("ar.no",    32'(a_if.no_cnt), 32'd0);
    model_reset();
    check_all("ar.async");
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 4'h0, 4'h0, "ar.idle");

    // N=7: four yes then three no, auto-close.
    b_if.start = 1;
    drive(0, 0, 0, 4'h0, 4'h0, "n7.start");
    b_if.start = 0;
    b_if.ballot_valid = 1; b_if.present = 7'b0001111; b_if.ballot = 7'b0001111;
    drive(0, 0, 0, 4'h0, 4'h0, "n7.b1");
    b_if.present = 7'b1110000; b_if.ballot = 7'b0000000;
    drive(0, 0, 0, 4'h0, 4'h0, "n7.b2");
    b_if.ballot_valid = 0; b_if.present = '0; b_if.ballot = '0;
    chk("n7.rv",    32'(b_if.result_valid), 32'd1);
    chk("n7.maj",   32'(b_if.maj), 32'd1);
    chk("n7.yes",   32'(b_if.yes_cnt), 32'd4);
    chk("n7.no",    32'(b_if.no_cnt), 32'd3);
    chk("n7.voted", 32'(b_if.voted), 32'h7F);
    chk("n7.busy",  32'(b_if.busy), 32'd0);

    // Random sessions against the model.
    for (int sess = 0; sess < 40; sess++) begin
      drive(1, 0, 0, 4'h0, 4'h0, "rnd.start");
      for (int cyc = 0; cyc < 6; cyc++) begin
        drive($urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0, 1'($urandom),
              4'($urandom), 4'($urandom), "rnd.step");
      end
      drive(0, 1, 0, 4'h0, 4'h0, "rnd.close");
      drive(1'($urandom), 0, 1'($urandom), 4'($urandom), 4'($urandom), "rnd.tail1");
      drive(0, 1, 0, 4'h0, 4'h0, "rnd.tail2");
      drive(0, 0, 0, 4'h0, 4'h0, "rnd.tail3");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
